led_pattern_detector: RTL and testbench

- Receive-side companion to the 8-bit LED pattern generator. It samples an 8-bit LED frame stream and identifies which of the eight generator patterns is running.
- Reports the 3-bit pattern id using the generator's pat_sel encoding, plus lock status and glitch pulses.
- Used as an on-chip self-checker and loopback monitor.

---
 rtl/led_pattern_detector.sv | 110 +++++++++++
 tb/tb_led_pattern_detector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_detector.sv
// led_pattern_detector: identifies which of the eight LED generator patterns is running from a sampled frame stream
module led_pattern_detector #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_valid,
  input  logic [7:0] led_in,
  output logic [2:0] pat_id,
  output logic       locked,
  output logic       lock_pulse,
  output logic       glitch
);
  typedef enum logic {ACQUIRE, LOCKED} state_t;
  localparam logic [7:0] LV [5] = '{8'h00, 8'h18, 8'h3C, 8'h7E, 8'hFF};
  state_t state, state_n;
  logic [7:0] prev, acc_mask, acc_n, cand, hit, acq_mask;
  logic [3:0] cnt, cnt_n, acq_cnt, miss_cnt, miss_n, miss_inc;
  logic [2:0] pat_n, idx;
  logic prev_valid, accept, trans, one_hot, lock_pulse_n, glitch_n;
  function automatic logic [7:0] kn(input int k);
    kn = (8'h80 >> k) | (8'h01 << k);
  endfunction
  function automatic logic [7:0] wk(input int k);
    wk = 8'h03 << k;
  endfunction
  assign accept = ena && frame_valid && !(led_in == prev && led_in != 8'h00);
  assign trans = accept && prev_valid;
  assign locked = state == LOCKED;
  // Adjacent-step patterns match when prev and cur are neighbours in their sequence
  always_comb begin
    cand = '0;
    for (int i = 0; i < 3; i++)
      cand[0] = cand[0] | (prev == kn(i) && led_in == kn(i + 1)) | (prev == kn(i + 1) && led_in == kn(i));
    for (int i = 0; i < 6; i++)
      cand[1] = cand[1] | (prev == wk(i) && led_in == wk(i + 1)) | (prev == wk(i + 1) && led_in == wk(i));
    for (int i = 0; i < 4; i++)
      cand[2] = cand[2] | (prev == LV[i] && led_in == LV[i + 1]) | (prev == LV[i + 1] && led_in == LV[i]);
    cand[3] = (prev == 8'h00 && led_in == 8'hFF) || (prev == 8'hFF && led_in == 8'h00);
    cand[4] = (prev == 8'hAA && led_in == 8'h55) || (prev == 8'h55 && led_in == 8'hAA);
    cand[5] = led_in == {prev[6:0], prev[7]} && prev != 8'h00 && prev != 8'hFF;
    cand[6] = led_in == {prev[6:0], prev[7] ^ prev[5] ^ prev[4] ^ prev[3]} && prev != 8'h00;
    cand[7] = prev == 8'h00 && led_in == 8'h00;
  end
  assign hit = acc_mask & cand;
  assign acq_mask = |hit ? hit : cand;
  assign acq_cnt = |hit ? (cnt == 4'd15 ? cnt : cnt + 4'd1) : {3'b000, |cand};
  assign one_hot = acq_mask != 8'h00 && (acq_mask & (acq_mask - 8'h01)) == 8'h00;
  assign miss_inc = miss_cnt + 4'd1;
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (acq_mask[i]) idx = 3'(i);
  end
  always_comb begin
    state_n = state;
    acc_n = acc_mask;
    cnt_n = cnt;
    miss_n = miss_cnt;
    pat_n = pat_id;
    lock_pulse_n = 1'b0;
    glitch_n = 1'b0;
    if (trans && state == ACQUIRE) begin
      acc_n = acq_mask;
      cnt_n = acq_cnt;
      if (one_hot && acq_cnt >= 4'(LOCK_COUNT)) begin
        state_n = LOCKED;
        pat_n = idx;
        lock_pulse_n = 1'b1;
        miss_n = '0;
      end
    end else if (trans) begin
      glitch_n = !cand[pat_id];
      miss_n = cand[pat_id] ? 4'd0 : miss_inc;
      if (!cand[pat_id] && miss_inc >= 4'(LOSS_COUNT)) begin
        state_n = ACQUIRE;
        miss_n = '0;
        acc_n = cand;
        cnt_n = {3'b000, |cand};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACQUIRE;
      prev <= '0;
      prev_valid <= 1'b0;
      acc_mask <= '0;
      cnt <= '0;
      miss_cnt <= '0;
      pat_id <= 3'b111;
      lock_pulse <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state <= state_n;
      acc_mask <= acc_n;
      cnt <= cnt_n;
      miss_cnt <= miss_n;
      pat_id <= pat_n;
      lock_pulse <= lock_pulse_n;
      glitch <= glitch_n;
      if (accept) begin
        prev <= led_in;
        prev_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_detector.sv
// tb_led_pattern_detector: directed frame sequences checked against a set-based model and literal expectations
module tb_led_pattern_detector;
  localparam int LOCK = 4;
  localparam int LOSS = 2;
  logic clk = 0, rst_n = 1, ena = 1, frame_valid = 0;
  logic [7:0] led_in = 0;
  logic [2:0] pat_id;
  logic locked, lock_pulse, glitch;
  int tests = 0, fails = 0;
  bit run = 0;

  led_pattern_detector #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_valid(frame_valid), .led_in(led_in),
    .pat_id(pat_id), .locked(locked), .lock_pulse(lock_pulse), .glitch(glitch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  int kn_t [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
  int wk_t [7] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};
  int lv_t [5] = '{8'h00, 8'h18, 8'h3C, 8'h7E, 8'hFF};

  function automatic int pos(input int v, input int kind);
    pos = -1;
    if (kind == 0) begin foreach (kn_t[i]) if (kn_t[i] == v) pos = i; end
    else if (kind == 1) begin foreach (wk_t[i]) if (wk_t[i] == v) pos = i; end
    else begin foreach (lv_t[i]) if (lv_t[i] == v) pos = i; end
  endfunction

  function automatic bit adj(input int p, input int c, input int kind);
    int a, b;
    a = pos(p, kind);
    b = pos(c, kind);
    adj = a >= 0 && b >= 0 && (a - b == 1 || b - a == 1);
  endfunction

  function automatic int mcand(input int p, input int c);
    int r, fb;
    r = 0;
    fb = ((p >> 7) ^ (p >> 5) ^ (p >> 4) ^ (p >> 3)) & 1;
    for (int k = 0; k < 3; k++) if (adj(p, c, k)) r += 1 << k;
    if ((p == 0 && c == 255) || (p == 255 && c == 0)) r += 8;
    if ((p == 170 && c == 85) || (p == 85 && c == 170)) r += 16;
    if (p != 0 && p != 255 && c == ((p * 2) % 256) + p / 128) r += 32;
    if (p != 0 && c == ((p * 2) % 256) + fb) r += 64;
    if (p == 0 && c == 0) r += 128;
    mcand = r;
  endfunction

  int m_prev = 0, m_acc = 0, m_cnt = 0, m_miss = 0, m_pat = 7;
  bit m_pv = 0, m_locked = 0, m_lp = 0, m_gl = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 0; m_pv = 0; m_acc = 0; m_cnt = 0; m_miss = 0;
      m_pat = 7; m_locked = 0; m_lp = 0; m_gl = 0;
    end else begin
      int c, h;
      m_lp = 0;
      m_gl = 0;
      if (ena && frame_valid && !(int'(led_in) == m_prev && led_in != 0)) begin
        if (m_pv) begin
          c = mcand(m_prev, int'(led_in));
          if (!m_locked) begin
            h = m_acc & c;
            if (h != 0) begin m_acc = h; if (m_cnt < 15) m_cnt++; end
            else begin m_acc = c; m_cnt = (c != 0); end
            if ($countones(m_acc) == 1 && m_cnt >= LOCK) begin
              m_locked = 1; m_lp = 1; m_miss = 0;
              for (int i = 0; i < 8; i++) if (m_acc == (1 << i)) m_pat = i;
            end
          end else if ((c >> m_pat) & 1) m_miss = 0;
          else begin
            m_gl = 1;
            m_miss++;
            if (m_miss >= LOSS) begin m_locked = 0; m_miss = 0; m_acc = c; m_cnt = (c != 0); end
          end
        end
        m_prev = int'(led_in);
        m_pv = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (run) begin
      chk("model_pat_id", int'(pat_id), m_pat);
      chk("model_locked", int'(locked), int'(m_locked));
      chk("model_lock_pulse", int'(lock_pulse), int'(m_lp));
      chk("model_glitch", int'(glitch), int'(m_gl));
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic send(input logic [7:0] v, input logic en = 1'b1);
    @(negedge clk); frame_valid = 1; led_in = v; ena = en;
    @(negedge clk); frame_valid = 0; ena = 1;
    #2;
  endtask

  initial begin
    do_reset();
    run = 1;
    #2;
    chk("reset_pat_id", int'(pat_id), 7);
    chk("reset_locked", int'(locked), 0);
    chk("reset_glitch", int'(glitch), 0);

    send(8'h81); send(8'h42); send(8'h24); send(8'h18); send(8'h18);
    chk("knight_no_lock_early", int'(locked), 0);
    send(8'h24);
    chk("knight_lock_pulse", int'(lock_pulse), 1);
    chk("knight_locked", int'(locked), 1);
    chk("knight_pat_id", int'(pat_id), 0);

    do_reset();
    send(8'hAA); send(8'h55); send(8'hAB); send(8'h57);
    chk("sparkle_not_yet", int'(locked), 0);
    send(8'hAF);
    chk("sparkle_locked", int'(locked), 1);
    chk("sparkle_pat_id", int'(pat_id), 6);

    do_reset();
    send(8'h00); send(8'hFF); send(8'h00); send(8'hFF); send(8'h00);
    chk("blink_pat_id", int'(pat_id), 3);
    send(8'h18);
    chk("loss_glitch1", int'(glitch), 1);
    chk("loss_still_locked", int'(locked), 1);
    send(8'h3C);
    chk("loss_glitch2", int'(glitch), 1);
    chk("loss_dropped", int'(locked), 0);
    chk("loss_pat_hold", int'(pat_id), 3);
    send(8'h7E); send(8'hFF);
    chk("relock_not_yet", int'(locked), 0);
    send(8'h7E);
    chk("relock_pulse", int'(lock_pulse), 1);
    chk("relock_no_glitch", int'(glitch), 0);
    chk("relock_pat_id", int'(pat_id), 2);

    do_reset();
    send(8'h03); send(8'h03); send(8'h03); send(8'h06, 1'b0); send(8'h0C);
    chk("enable_no_lock", int'(locked), 0);
    chk("enable_pat_id", int'(pat_id), 7);

    do_reset();
    send(8'h07); send(8'h0E); send(8'h1C); send(8'h38); send(8'h70);
    chk("marquee_pat_id", int'(pat_id), 5);
    chk("marquee_locked", int'(locked), 1);
    @(negedge clk); rst_n = 0;
    #1;
    chk("async_rst_pat_id", int'(pat_id), 7);
    chk("async_rst_locked", int'(locked), 0);
    @(negedge clk); rst_n = 1;
    send(8'h07); send(8'h0E); send(8'h1C); send(8'h38);
    chk("marquee_after_rst_no_lock", int'(locked), 0);
    send(8'h70);
    chk("marquee_relock", int'(locked), 1);
    chk("marquee_relock_pat", int'(pat_id), 5);

    repeat (3) @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
